// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision constants for the FP datapath and the
// field positions used when rounding a normalised 32-bit magnitude.
package fp_pkg;

  localparam int FP_BIAS   = 127;
  localparam int FP_EXP_W  = 8;
  localparam int FP_FRAC_W = 23;
  localparam int INT_W     = 32;
  localparam int CNT_W     = 5;

  // Field slices of a normalised magnitude (hidden one sits at bit 31)
  localparam int MAG_FRAC_MSB = INT_W - 2;
  localparam int MAG_FRAC_LSB = INT_W - 1 - FP_FRAC_W;
  localparam int MAG_G_BIT    = MAG_FRAC_LSB - 1;

  // Exponent of a magnitude whose leading one is at bit 31
  localparam logic [FP_EXP_W-1:0] EXP_TOP = FP_EXP_W'(FP_BIAS + INT_W - 1);

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_FRAC_W-1:0] frac;
  } fp32_t;

endpackage

// File: rtl/int_to_float_seq_if.sv
// Valid/ready bundle between the FP front end and the integer-to-float
// converter; master drives operands and result acceptance.
interface int_to_float_seq_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_int;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_float;
  logic        out_inexact;
  logic        busy;

  modport master (
    output in_valid, in_int, out_ready,
    input  in_ready, out_valid, out_float, out_inexact, busy
  );

  modport slave (
    input  in_valid, in_int, out_ready,
    output in_ready, out_valid, out_float, out_inexact, busy
  );

endinterface

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of a normalised 32-bit magnitude to a single-precision
// exponent/fraction; cnt_i is the left-shift applied during normalisation.
module fp_round_rne
  import fp_pkg::*;
(
  input  logic [INT_W-1:0]     mag_i,
  input  logic [CNT_W-1:0]     cnt_i,
  output logic [FP_EXP_W-1:0]  exp_o,
  output logic [FP_FRAC_W-1:0] frac_o,
  output logic                 inexact_o
);

  logic [FP_FRAC_W-1:0] frac_s;
  logic [FP_FRAC_W:0]   frac_inc_s;
  logic [FP_EXP_W-1:0]  exp_s;
  logic                 guard_s;
  logic                 sticky_s;
  logic                 round_up_s;

  // Guard/sticky extraction, RNE increment and exponent bump on fraction carry
  always_comb begin
    frac_s     = mag_i[MAG_FRAC_MSB:MAG_FRAC_LSB];
    guard_s    = mag_i[MAG_G_BIT];
    sticky_s   = |mag_i[MAG_G_BIT-1:0];
    round_up_s = guard_s & (sticky_s | frac_s[0]);
    frac_inc_s = {1'b0, frac_s} + {{FP_FRAC_W{1'b0}}, round_up_s};
    exp_s      = EXP_TOP - {3'b000, cnt_i};
    if (mag_i == 32'd0) begin
      exp_o     = 8'd0;
      frac_o    = 23'd0;
      inexact_o = 1'b0;
    end else begin
      exp_o     = exp_s + {7'd0, frac_inc_s[FP_FRAC_W]};
      frac_o    = frac_inc_s[FP_FRAC_W-1:0];
      inexact_o = guard_s | sticky_s;
    end
  end

endmodule

// File: rtl/int_to_float_seq.sv
// Multi-cycle 32-bit integer to IEEE-754 single converter: one operand in
// flight, 1-bit-per-cycle normalisation, round-to-nearest-even.
module int_to_float_seq
  import fp_pkg::*;
#(
  parameter bit SIGNED_IN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  int_to_float_seq_if.slave        cvt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ABS   = 3'd1,
    S_NORM  = 3'd2,
    S_ROUND = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               state_q;
  logic [INT_W-1:0]     op_q;
  logic [INT_W-1:0]     mag_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 sign_q;
  fp32_t                out_float_q;
  logic                 out_inexact_q;
  logic                 out_valid_q;
  logic                 in_ready_q;
  logic                 busy_q;

  logic                 neg_d;
  logic [INT_W-1:0]     mag_abs_d;
  logic [FP_EXP_W-1:0]  rnd_exp_s;
  logic [FP_FRAC_W-1:0] rnd_frac_s;
  logic                 rnd_inexact_s;

  // Sign and magnitude of the captured operand; -2^31 maps onto 0x80000000
  always_comb begin
    neg_d = SIGNED_IN & op_q[INT_W-1];
    if (neg_d) begin
      mag_abs_d = 32'd0 - op_q;
    end else begin
      mag_abs_d = op_q;
    end
  end

  fp_round_rne u_round (
    .mag_i     (mag_q),
    .cnt_i     (cnt_q),
    .exp_o     (rnd_exp_s),
    .frac_o    (rnd_frac_s),
    .inexact_o (rnd_inexact_s)
  );

  // Conversion FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      op_q          <= 32'd0;
      mag_q         <= 32'd0;
      cnt_q         <= 5'd0;
      sign_q        <= 1'b0;
      out_float_q   <= 32'd0;
      out_inexact_q <= 1'b0;
      out_valid_q   <= 1'b0;
      in_ready_q    <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cvt.in_valid) begin
            op_q       <= cvt.in_int;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_ABS;
          end
        end
        S_ABS: begin
          sign_q <= neg_d;
          mag_q  <= mag_abs_d;
          cnt_q  <= 5'd0;
          // A zero magnitude skips normalisation; the rounder maps it to +0
          if (mag_abs_d == 32'd0) begin
            state_q <= S_ROUND;
          end else begin
            state_q <= S_NORM;
          end
        end
        S_NORM: begin
          if (!mag_q[INT_W-1]) begin
            mag_q <= {mag_q[INT_W-2:0], 1'b0};
            cnt_q <= cnt_q + 5'd1;
          end else begin
            state_q <= S_ROUND;
          end
        end
        S_ROUND: begin
          out_float_q   <= {sign_q, rnd_exp_s, rnd_frac_s};
          out_inexact_q <= rnd_inexact_s;
          out_valid_q   <= 1'b1;
          state_q       <= S_DONE;
        end
        S_DONE: begin
          if (cvt.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign cvt.in_ready    = in_ready_q;
  assign cvt.out_valid   = out_valid_q;
  assign cvt.out_float   = out_float_q;
  assign cvt.out_inexact = out_inexact_q;
  assign cvt.busy        = busy_q;

endmodule

// File: tb/tb_int_to_float_seq.sv
// Bench for int_to_float_seq: a signed and an unsigned instance converted in
// lockstep and compared with an arithmetic rounding model.
module tb_int_to_float_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  int_to_float_seq_if if_s ();
  int_to_float_seq_if if_u ();

  int_to_float_seq #(.SIGNED_IN(1'b1)) dut_s (.clk(clk), .rst_n(rst_n), .cvt(if_s));
  int_to_float_seq #(.SIGNED_IN(1'b0)) dut_u (.clk(clk), .rst_n(rst_n), .cvt(if_u));

  // Exact value rounded to nearest-even with plain integer arithmetic
  function automatic void ref_model(input logic [31:0] v, input bit signed_in,
                                    output logic [31:0] f, output logic inx, output int lat);
    longint mag, q, rem, half;
    bit     neg;
    int     p, sh, e;
    neg = signed_in && v[31];
    mag = longint'({32'd0, v});
    if (neg) mag = 64'sd4294967296 - mag;
    if (mag == 0) begin
      f = 32'h0; inx = 1'b0; lat = 2;
      return;
    end
    p = 31;
    while (((mag >> p) & 1) == 0) p--;
    e = 127 + p;
    rem = 0;
    if (p <= 23) begin
      q = mag << (23 - p);
    end else begin
      sh   = p - 23;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        e = e + 1;
      end
    end
    f   = {neg, 8'(e), 23'(q)};
    inx = (rem != 0);
    lat = 3 + (31 - p);
  endfunction

  // Drive one operand to both instances, capture results and latencies, then accept them
  task automatic run_op(input logic [31:0] v,
                        output logic [31:0] f_s, output logic x_s, output int l_s,
                        output logic [31:0] f_u, output logic x_u, output int l_u);
    int cyc;
    if_s.in_int = v;  if_u.in_int = v;
    if_s.in_valid = 1'b1;  if_u.in_valid = 1'b1;
    @(posedge clk); #1;
    if_s.in_valid = 1'b0;  if_u.in_valid = 1'b0;
    l_s = -1; l_u = -1; cyc = 0;
    f_s = 32'h0; x_s = 1'b0; f_u = 32'h0; x_u = 1'b0;
    while ((l_s < 0 || l_u < 0) && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
      if (l_s < 0 && if_s.out_valid === 1'b1) begin
        l_s = cyc; f_s = if_s.out_float; x_s = if_s.out_inexact;
      end
      if (l_u < 0 && if_u.out_valid === 1'b1) begin
        l_u = cyc; f_u = if_u.out_float; x_u = if_u.out_inexact;
      end
    end
    if_s.out_ready = 1'b1;  if_u.out_ready = 1'b1;
    @(posedge clk); #1;
    if_s.out_ready = 1'b0;  if_u.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    if_s.in_valid = 1'b0; if_s.in_int = 32'h0; if_s.out_ready = 1'b0;
    if_u.in_valid = 1'b0; if_u.in_int = 32'h0; if_u.out_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    n_vec++;
    if ({if_s.in_ready, if_s.out_valid, if_s.out_float, if_s.out_inexact, if_s.busy} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_s: got rdy=%b vld=%b f=%h x=%b busy=%b, want 1 0 00000000 0 0",
               if_s.in_ready, if_s.out_valid, if_s.out_float, if_s.out_inexact, if_s.busy);
    end
    n_vec++;
    if ({if_u.in_ready, if_u.out_valid, if_u.out_float, if_u.out_inexact, if_u.busy} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_u: got rdy=%b vld=%b f=%h x=%b busy=%b, want 1 0 00000000 0 0",
               if_u.in_ready, if_u.out_valid, if_u.out_float, if_u.out_inexact, if_u.busy);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [31:0] ops   [7] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0100_0001,
                               32'h0100_0003, 32'h7FFF_FFFF, 32'h0000_0000};
    logic [31:0] exp_s [7] = '{32'h3F80_0000, 32'hBF80_0000, 32'hCF00_0000, 32'h4B80_0000,
                               32'h4B80_0002, 32'h4F00_0000, 32'h0000_0000};
    logic [31:0] exp_u [7] = '{32'h3F80_0000, 32'h4F80_0000, 32'h4F00_0000, 32'h4B80_0000,
                               32'h4B80_0002, 32'h4F00_0000, 32'h0000_0000};
    logic        exp_x [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    int          lat_s [7] = '{34, 34, 3, 10, 10, 4, 2};
    logic [31:0] f_s, f_u;
    logic        x_s, x_u;
    int          l_s, l_u;
    for (int i = 0; i < 7; i++) begin
      run_op(ops[i], f_s, x_s, l_s, f_u, x_u, l_u);
      n_vec++;
      if ({f_s, x_s} !== {exp_s[i], exp_x[i]}) begin
        n_err++;
        $display("FAIL dir_s[%0d] op=%h: got %h/%b want %h/%b", i, ops[i], f_s, x_s, exp_s[i], exp_x[i]);
      end
      n_vec++;
      if (f_u !== exp_u[i]) begin
        n_err++;
        $display("FAIL dir_u[%0d] op=%h: got %h want %h", i, ops[i], f_u, exp_u[i]);
      end
      n_vec++;
      if (l_s != lat_s[i]) begin
        n_err++;
        $display("FAIL dir_lat[%0d] op=%h: got %0d want %0d", i, ops[i], l_s, lat_s[i]);
      end
      n_vec++;
      if ({if_s.in_ready, if_s.out_valid, if_u.in_ready, if_u.out_valid} !== 4'b1010) begin
        n_err++;
        $display("FAIL dir_hs[%0d]: got rdy/vld s=%b%b u=%b%b want 10 10", i,
                 if_s.in_ready, if_s.out_valid, if_u.in_ready, if_u.out_valid);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] v, f_s, f_u, ef_s, ef_u;
    logic        x_s, x_u, ex_s, ex_u;
    int          l_s, l_u, el_s, el_u;
    for (int i = 0; i < 40; i++) begin
      v = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) v = 32'd0 - v;
      ref_model(v, 1'b1, ef_s, ex_s, el_s);
      ref_model(v, 1'b0, ef_u, ex_u, el_u);
      run_op(v, f_s, x_s, l_s, f_u, x_u, l_u);
      n_vec++;
      if ({f_s, x_s} !== {ef_s, ex_s}) begin
        n_err++;
        $display("FAIL rnd_s op=%h: got %h/%b want %h/%b", v, f_s, x_s, ef_s, ex_s);
      end
      n_vec++;
      if ({f_u, x_u} !== {ef_u, ex_u}) begin
        n_err++;
        $display("FAIL rnd_u op=%h: got %h/%b want %h/%b", v, f_u, x_u, ef_u, ex_u);
      end
      n_vec++;
      if (l_s != el_s) begin
        n_err++;
        $display("FAIL rnd_lat_s op=%h: got %0d want %0d", v, l_s, el_s);
      end
      n_vec++;
      if (l_u != el_u) begin
        n_err++;
        $display("FAIL rnd_lat_u op=%h: got %0d want %0d", v, l_u, el_u);
      end
      n_vec++;
      if ({if_s.in_ready, if_s.out_valid, if_u.in_ready, if_u.out_valid} !== 4'b1010) begin
        n_err++;
        $display("FAIL rnd_hs op=%h: got rdy/vld s=%b%b u=%b%b want 10 10", v,
                 if_s.in_ready, if_s.out_valid, if_u.in_ready, if_u.out_valid);
      end
    end
  endtask

  task automatic test_hold;
    logic [31:0] v, ef;
    logic        ex;
    int          el, cyc;
    v = 32'h0012_3457;
    ref_model(v, 1'b1, ef, ex, el);
    if_s.in_int = v;  if_u.in_int = v;
    if_s.in_valid = 1'b1;  if_u.in_valid = 1'b1;
    @(posedge clk); #1;
    if_s.in_valid = 1'b0;  if_u.in_valid = 1'b0;
    cyc = 0;
    while (if_s.out_valid !== 1'b1 && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_vec++;
    if (cyc != el) begin
      n_err++;
      $display("FAIL hold_lat: got %0d want %0d", cyc, el);
    end
    n_vec++;
    if ({if_s.out_float, if_s.out_inexact} !== {ef, ex}) begin
      n_err++;
      $display("FAIL hold_val: got %h/%b want %h/%b", if_s.out_float, if_s.out_inexact, ef, ex);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({if_s.out_valid, if_s.in_ready, if_s.busy, if_s.out_float} !== {1'b1, 1'b0, 1'b1, ef}) begin
        n_err++;
        $display("FAIL hold_cyc%0d: got vld=%b rdy=%b busy=%b f=%h want 1 0 1 %h", i,
                 if_s.out_valid, if_s.in_ready, if_s.busy, if_s.out_float, ef);
      end
    end
    if_s.out_ready = 1'b1;  if_u.out_ready = 1'b1;
    @(posedge clk); #1;
    if_s.out_ready = 1'b0;  if_u.out_ready = 1'b0;
    n_vec++;
    if ({if_s.in_ready, if_s.out_valid, if_s.busy, if_u.in_ready} !== 4'b1001) begin
      n_err++;
      $display("FAIL hold_release: got rdy=%b vld=%b busy=%b rdy_u=%b want 1 0 0 1",
               if_s.in_ready, if_s.out_valid, if_s.busy, if_u.in_ready);
    end
  endtask

  task automatic test_midreset;
    logic [31:0] f_s, f_u, ef_s, ef_u;
    logic        x_s, x_u, ex_s, ex_u;
    int          l_s, l_u, el_s, el_u;
    bit          seen;
    if_s.in_int = 32'h0000_0001;  if_u.in_int = 32'h0000_0001;
    if_s.in_valid = 1'b1;  if_u.in_valid = 1'b1;
    @(posedge clk); #1;
    if_s.in_valid = 1'b0;  if_u.in_valid = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({if_s.in_ready, if_s.out_valid, if_s.out_float, if_s.out_inexact, if_s.busy} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL midrst_s: got rdy=%b vld=%b f=%h x=%b busy=%b, want 1 0 00000000 0 0",
               if_s.in_ready, if_s.out_valid, if_s.out_float, if_s.out_inexact, if_s.busy);
    end
    n_vec++;
    if ({if_u.in_ready, if_u.out_valid, if_u.busy} !== 3'b100) begin
      n_err++;
      $display("FAIL midrst_u: got rdy=%b vld=%b busy=%b want 1 0 0", if_u.in_ready, if_u.out_valid, if_u.busy);
    end
    #3 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk); #1;
      if (if_s.out_valid !== 1'b0 || if_u.out_valid !== 1'b0 || if_s.busy !== 1'b0) seen = 1'b1;
    end
    n_vec++;
    if (seen) begin
      n_err++;
      $display("FAIL midrst_abort: got activity after reset, want none");
    end
    ref_model(32'hFFFF_FFF5, 1'b1, ef_s, ex_s, el_s);
    ref_model(32'hFFFF_FFF5, 1'b0, ef_u, ex_u, el_u);
    run_op(32'hFFFF_FFF5, f_s, x_s, l_s, f_u, x_u, l_u);
    n_vec++;
    if ({f_s, x_s, l_s} !== {ef_s, ex_s, el_s}) begin
      n_err++;
      $display("FAIL midrst_next_s: got %h/%b lat %0d want %h/%b lat %0d", f_s, x_s, l_s, ef_s, ex_s, el_s);
    end
    n_vec++;
    if ({f_u, x_u, l_u} !== {ef_u, ex_u, el_u}) begin
      n_err++;
      $display("FAIL midrst_next_u: got %h/%b lat %0d want %h/%b lat %0d", f_u, x_u, l_u, ef_u, ex_u, el_u);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
